// File: rtl/alu_sequencer.sv
// alu_sequencer: steps a downstream 2-bit ALU through operand A, operand B and
// select loads driven by a debounced-level load input, then captures the result.
module alu_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LD,
    input  logic       CLR,
    input  logic [1:0] SW,
    input  logic [3:0] ALU_O,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic [1:0] S,
    output logic [3:0] R,
    output logic       VALID,
    output logic [3:0] CNT,
    output logic [2:0] STATE
);

    localparam int unsigned OPW  = 2;
    localparam int unsigned RESW = 4;
    localparam int unsigned CNTW = 4;
    localparam int unsigned STW  = 3;

    typedef enum logic [STW-1:0] {
        IDLE  = 3'd0,
        GOT_A = 3'd1,
        GOT_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic [OPW-1:0]    s_q, s_d;
    logic [RESW-1:0]   r_q, r_d;
    logic              valid_q, valid_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ld_s1_q, ld_s2_q;
    logic              step;

    // Two-flop synchronizer for the asynchronous load level; CLR leaves it alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_s1_q <= 1'b0;
            ld_s2_q <= 1'b0;
        end else begin
            ld_s1_q <= LD;
            ld_s2_q <= ld_s1_q;
        end
    end

    // One-cycle step pulse per synchronized rising edge of LD.
    assign step = ld_s1_q & ~ld_s2_q;

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            r_q     <= r_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath updates; clear overrides any pending step.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        r_d     = r_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (CLR) begin
            state_d = IDLE;
            a_d     = '0;
            b_d     = '0;
            s_d     = '0;
            r_d     = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (step) begin
                        a_d     = SW;
                        state_d = GOT_A;
                    end
                end
                GOT_A: begin
                    if (step) begin
                        b_d     = SW;
                        state_d = GOT_B;
                    end
                end
                GOT_B: begin
                    if (step) begin
                        s_d     = SW;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // ALU has had a full cycle with the new select; capture it.
                    r_d     = ALU_O;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = DONE;
                end
                DONE: begin
                    if (step) begin
                        a_d     = SW;
                        valid_d = 1'b0;
                        state_d = GOT_A;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign S     = s_q;
    assign R     = r_q;
    assign VALID = valid_q;
    assign CNT   = cnt_q;
    assign STATE = STW'(state_q);

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random load/clear traffic,
// checked every cycle against a step-level reference model.
module tb_alu_sequencer;

    logic       CLK;
    logic       RST;
    logic       LD;
    logic       CLR;
    logic [1:0] SW;
    logic [3:0] ALU_O;
    logic [1:0] A;
    logic [1:0] B;
    logic [1:0] S;
    logic [3:0] R;
    logic       VALID;
    logic [3:0] CNT;
    logic [2:0] STATE;

    int n_checks = 0;
    int n_fails  = 0;

    alu_sequencer dut (
        .CLK   (CLK),
        .RST   (RST),
        .LD    (LD),
        .CLR   (CLR),
        .SW    (SW),
        .ALU_O (ALU_O),
        .A     (A),
        .B     (B),
        .S     (S),
        .R     (R),
        .VALID (VALID),
        .CNT   (CNT),
        .STATE (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in ALU: 0 sub, 1 add, 2 and, 3 or.
    function automatic logic [3:0] alu_f(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
        logic [3:0] x;
        logic [3:0] y;
        x = {2'b00, a};
        y = {2'b00, b};
        case (s)
            2'd0:    return x - y;
            2'd1:    return x + y;
            2'd2:    return x & y;
            default: return x | y;
        endcase
    endfunction

    assign ALU_O = alu_f(A, B, S);

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: LD history, operation step and captured values.
    logic [1:0] ld_hist = 2'b00;   // [0] newest sample, [1] previous
    int         m_step  = 0;       // 0 idle,1 have A,2 have B,3 executing,4 done
    logic [1:0] m_a = 0, m_b = 0, m_s = 0;
    logic [3:0] m_r = 0;
    logic       m_v = 0;
    int         m_cnt = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_hist = 2'b00;
            m_step  = 0;
            m_a = 0; m_b = 0; m_s = 0; m_r = 0; m_v = 0;
            m_cnt = 0;
        end else begin
            bit p;
            p = ld_hist[0] && !ld_hist[1];
            ld_hist = {ld_hist[0], LD};
            if (CLR) begin
                m_step = 0;
                m_a = 0; m_b = 0; m_s = 0; m_r = 0; m_v = 0;
            end else if (m_step == 3) begin
                m_r    = alu_f(m_a, m_b, m_s);
                m_v    = 1;
                m_cnt  = (m_cnt + 1) % 16;
                m_step = 4;
            end else if (p) begin
                case (m_step)
                    0: begin m_a = SW; m_step = 1; end
                    1: begin m_b = SW; m_step = 2; end
                    2: begin m_s = SW; m_step = 3; end
                    default: begin m_a = SW; m_v = 0; m_step = 1; end
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            check("cyc_state", {1'b0, STATE}, 4'(m_step));
            check("cyc_a", {2'b00, A}, {2'b00, m_a});
            check("cyc_b", {2'b00, B}, {2'b00, m_b});
            check("cyc_s", {2'b00, S}, {2'b00, m_s});
            check("cyc_r", R, m_r);
            check("cyc_valid", {3'b000, VALID}, {3'b000, m_v});
            check("cyc_cnt", CNT, 4'(m_cnt));
        end
    end

    task automatic pulse(input logic [1:0] sw);
        @(negedge CLK);
        SW = sw;
        LD = 1'b1;
        repeat (3) @(negedge CLK);
        LD = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic clear_once();
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
    endtask

    // Raise LD and wait (bounded) until the DUT reports the EXEC state.
    task automatic go_exec(input logic [1:0] sw, output bit found);
        found = 0;
        @(negedge CLK);
        SW = sw;
        LD = 1'b1;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge CLK);
            if (STATE == 3'd3) found = 1;
        end
    endtask

    initial begin
        bit found;
        RST = 1'b1; LD = 1'b0; CLR = 1'b0; SW = 2'd0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Reset then idle.
        repeat (5) @(negedge CLK);
        check("rst_state", {1'b0, STATE}, 4'd0);
        check("rst_a", {2'b00, A}, 4'd0);
        check("rst_b", {2'b00, B}, 4'd0);
        check("rst_s", {2'b00, S}, 4'd0);
        check("rst_r", R, 4'd0);
        check("rst_valid", {3'b000, VALID}, 4'd0);
        check("rst_cnt", CNT, 4'd0);

        // Full sequence 2,3,1 -> add gives 5, captured one cycle after EXEC.
        pulse(2'd2);
        pulse(2'd3);
        go_exec(2'd1, found);
        check("seq_exec_reached", {3'b000, found}, 4'd1);
        check("seq_r_in_exec", R, 4'd0);
        @(negedge CLK);
        check("seq_state", {1'b0, STATE}, 4'd4);
        check("seq_a", {2'b00, A}, 4'd2);
        check("seq_b", {2'b00, B}, 4'd3);
        check("seq_s", {2'b00, S}, 4'd1);
        check("seq_r", R, 4'd5);
        check("seq_valid", {3'b000, VALID}, 4'd1);
        check("seq_cnt", CNT, 4'd1);
        LD = 1'b0;
        repeat (3) @(negedge CLK);

        // LD held high for 20 cycles from IDLE gives a single step.
        clear_once();
        SW = 2'd1;
        LD = 1'b1;
        repeat (20) @(negedge CLK);
        check("hold_a", {2'b00, A}, 4'd1);
        check("hold_state", {1'b0, STATE}, 4'd1);
        LD = 1'b0;
        repeat (3) @(negedge CLK);
        check("hold_state_after", {1'b0, STATE}, 4'd1);
        check("hold_cnt", CNT, 4'd1);

        // Sixteen sequences: counter passes through 0 and returns to 1.
        clear_once();
        for (int i = 0; i < 16; i++) begin
            pulse(2'($urandom));
            pulse(2'($urandom));
            pulse(2'($urandom));
            if (i == 14) check("wrap_cnt_zero", CNT, 4'd0);
        end
        check("wrap_cnt", CNT, 4'd1);
        check("wrap_valid", {3'b000, VALID}, 4'd1);

        // CLR coincident with the step pulse in GOT_B.
        pulse(2'd3);
        pulse(2'd2);
        check("clr_pre_state", {1'b0, STATE}, 4'd2);
        @(negedge CLK);
        SW = 2'd3;
        LD = 1'b1;
        @(negedge CLK);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        check("clr_state", {1'b0, STATE}, 4'd0);
        check("clr_a", {2'b00, A}, 4'd0);
        check("clr_b", {2'b00, B}, 4'd0);
        check("clr_s", {2'b00, S}, 4'd0);
        check("clr_r", R, 4'd0);
        check("clr_valid", {3'b000, VALID}, 4'd0);
        check("clr_cnt", CNT, 4'd1);
        LD = 1'b0;
        repeat (3) @(negedge CLK);
        check("clr_no_step", {1'b0, STATE}, 4'd0);

        // Asynchronous reset between edges while in EXEC.
        pulse(2'd1);
        pulse(2'd2);
        go_exec(2'd3, found);
        check("rst_exec_reached", {3'b000, found}, 4'd1);
        #1;
        RST = 1'b1;
        #1;
        check("arst_state", {1'b0, STATE}, 4'd0);
        check("arst_a", {2'b00, A}, 4'd0);
        check("arst_b", {2'b00, B}, 4'd0);
        check("arst_s", {2'b00, S}, 4'd0);
        check("arst_r", R, 4'd0);
        check("arst_valid", {3'b000, VALID}, 4'd0);
        check("arst_cnt", CNT, 4'd0);
        LD = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("arst_cnt_after", CNT, 4'd0);
        check("arst_state_after", {1'b0, STATE}, 4'd0);

        // Random load/select/clear traffic checked by the per-cycle model.
        for (int i = 0; i < 600; i++) begin
            @(negedge CLK);
            SW  = 2'($urandom);
            if ($urandom_range(0, 2) == 0) LD = ~LD;
            CLR = ($urandom_range(0, 39) == 0);
        end
        @(negedge CLK);
        LD = 1'b0;
        CLR = 1'b0;
        repeat (4) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d checks done", n_checks);
        $fatal(1, "timeout");
    end

endmodule
